// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory and pipeline-side signal bundle for
//               fetch_stage; master = fetch stage, slave = memory/pipeline.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        illegal_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, pc_plus4_o, valid_o, illegal_o,
        input  imem_ack_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, pc_plus4_o, valid_o, illegal_o,
        output imem_ack_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with redirect/kill handling and a 1-entry
//               skid buffer. Define FETCH_ILLEGAL_CHECK_EN to enable the
//               unsupported-opcode check (illegal words become NOP).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    fetch_stage_if.master  bus
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH     = 2'd1,
        S_WAIT_FULL = 2'd2,
        S_KILL      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_req;

    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic        r_illegal;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc_plus4;
    logic        r_skid_illegal;

    logic [31:0] w_tgt;
    logic [31:0] w_pc_next4;
    logic        w_ack;
    logic        w_slot_free;
    logic        w_take;
    logic [31:0] w_instr;
    logic        w_illegal;

    assign w_tgt       = bus.redirect_pc_i & c_word_mask;
    assign w_pc_next4  = r_pc + c_pc_step;
    assign w_ack       = w_req & bus.imem_ack_i;
    assign w_slot_free = ~r_valid | ~bus.stall_i;
    // Only data fetched in FETCH without a redirect is ever kept.
    assign w_take      = (r_state == S_FETCH) & w_ack & ~bus.redirect_i;

`ifdef FETCH_ILLEGAL_CHECK_EN
    always_comb begin
        w_illegal = 1'b1;
        case (bus.imem_rdata_i[31:26])
            6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b001000, 6'b001010: w_illegal = 1'b0;
            default:                         w_illegal = 1'b1;
        endcase
        w_instr = w_illegal ? 32'h0000_0000 : bus.imem_rdata_i;
    end
`else
    always_comb begin
        w_illegal = 1'b0;
        w_instr   = bus.imem_rdata_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (bus.redirect_i) begin
                    w_state_next = bus.imem_ack_i ? S_FETCH : S_KILL;
                end else if (bus.imem_ack_i && !w_slot_free) begin
                    w_state_next = S_WAIT_FULL;
                end
            end
            S_WAIT_FULL: begin
                if (bus.redirect_i || !bus.stall_i) begin
                    w_state_next = S_FETCH;
                end
            end
            S_KILL: begin
                w_req = 1'b1;
                if (bus.imem_ack_i) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // PC and saved redirect target
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc     <= RESET_PC;
            r_target <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE, S_WAIT_FULL: begin
                    if (bus.redirect_i) r_pc <= w_tgt;
                end
                S_FETCH: begin
                    if (bus.redirect_i) begin
                        if (bus.imem_ack_i) r_pc     <= w_tgt;
                        else                r_target <= w_tgt;
                    end else if (bus.imem_ack_i) begin
                        r_pc <= w_pc_next4;
                    end
                end
                S_KILL: begin
                    if (bus.redirect_i) r_target <= w_tgt;
                    if (bus.imem_ack_i) r_pc <= bus.redirect_i ? w_tgt : r_target;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Output slot and skid buffer; the skid is occupied exactly in WAIT_FULL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr         <= 32'h0000_0000;
            r_pc_plus4      <= 32'h0000_0000;
            r_valid         <= 1'b0;
            r_illegal       <= 1'b0;
            r_skid_instr    <= 32'h0000_0000;
            r_skid_pc_plus4 <= 32'h0000_0000;
            r_skid_illegal  <= 1'b0;
        end else if (bus.redirect_i) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_take) begin
            if (w_slot_free) begin
                r_instr    <= w_instr;
                r_pc_plus4 <= w_pc_next4;
                r_valid    <= 1'b1;
                r_illegal  <= w_illegal;
            end else begin
                r_skid_instr    <= w_instr;
                r_skid_pc_plus4 <= w_pc_next4;
                r_skid_illegal  <= w_illegal;
            end
        end else if (r_state == S_WAIT_FULL && !bus.stall_i) begin
            r_instr    <= r_skid_instr;
            r_pc_plus4 <= r_skid_pc_plus4;
            r_valid    <= 1'b1;
            r_illegal  <= r_skid_illegal;
        end else if (!bus.stall_i) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end
    end

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_pc;
    assign bus.instr_o     = r_instr;
    assign bus.pc_plus4_o  = r_pc_plus4;
    assign bus.valid_o     = r_valid;
    assign bus.illegal_o   = r_illegal;

endmodule

`default_nettype wire
